uart_baud_gen_frac: RTL
=======================

# uart_baud_gen_frac

Parametrised baud-rate tick generator for the CoreUART family. It divides the system clock by a programmable integer, plus a fraction of up to FRAC_WIDTH bits, to produce the oversampling `baud_clock` strobe and the once-per-bit `xmit_pulse` strobe. The fraction uses a phase accumulator, which replaces the fixed 3-bit fraction lookup. It sits between the UART control registers and the tx/rx shifters, and adds enable gating and a synchronous resync (`load`).

## Interface
- CNT_WIDTH, 13: width of integer divisor `baud_val` and internal down-counter.
- FRAC_WIDTH, 3: width of fractional divisor `baud_frac`; range 1..8.
- OVERSAMPLE, 16: `baud_clock` ticks per bit; power of two, range 4..32.

- clk  in  1  system clock; all logic rising-edge.
- reset_n  in  1  asynchronous, active-low reset.
- enable  in  1  generator run enable; low holds the block in its idle state.
- load  in  1  single-cycle synchronous resync strobe.
- baud_val  in  CNT_WIDTH  integer divisor; base tick interval is baud_val+1 clocks.
- baud_frac  in  FRAC_WIDTH  fractional divisor, in units of 2^-FRAC_WIDTH clock.
- baud_clock  out  1  one-clock oversampling tick, registered.
- xmit_pulse  out  1  one-clock bit strobe, registered; coincides with every OVERSAMPLE-th baud_clock.

## Operation
- State:
  - cnt[CNT_WIDTH-1:0] down-counter.
  - acc[FRAC_WIDTH-1:0] phase accumulator.
  - stretch flag.
  - tick_cntr[log2(OVERSAMPLE)-1:0].
  - baud_clock and xmit_pulse registers.
- Per-cycle priority, highest first:
  1. enable=0: cnt, acc, stretch and tick_cntr are cleared to 0; baud_clock=0; xmit_pulse=0.
  2. load=1: cnt<=baud_val; acc, stretch and tick_cntr are cleared to 0; outputs are driven 0.
  3. cnt!=0: cnt<=cnt-1; outputs are driven 0.
  4. cnt==0 and stretch=1 (hold cycle): stretch<=0; cnt holds at 0; outputs are driven 0.
  5. cnt==0 and stretch=0 (tick):
     - baud_clock<=1; cnt<=baud_val.
     - {carry,acc}<=acc+baud_frac (FRAC_WIDTH+1-bit sum); stretch<=carry.
     - tick_cntr<=tick_cntr+1, wrapping at OVERSAMPLE.
     - xmit_pulse<=(tick_cntr==OVERSAMPLE-1).
- Resulting tick interval: baud_val+1 clocks, or baud_val+2 when the preceding tick carried.
- Average interval: baud_val+1+baud_frac/2^FRAC_WIDTH clocks.
- Changes to baud_val or baud_frac take effect at the next tick (reload point). No glitch, partial interval or counter corruption is allowed.
- baud_val=0: ticks on every clock when baud_frac=0. Otherwise ticks are interleaved with hold cycles.
- baud_frac=0: stretch is never set. The behaviour then equals a plain integer divider.
- acc wraps modulo 2^FRAC_WIDTH with no saturation. The carry is consumed exactly once.

## Timing
- Reset values: baud_clock=0 and xmit_pulse=0. All internal state is 0.
- Reset is asynchronous on assertion. On deassertion, the first active edge with enable=1 produces a tick, because cnt=0. baud_clock is high for that one cycle.
- enable rising: the first baud_clock is registered on the first edge sampling enable=1. The first xmit_pulse comes with tick number OVERSAMPLE.
- load: the first baud_clock arrives baud_val+1 edges after the load edge.
- baud_clock and xmit_pulse are always exactly one cycle wide. xmit_pulse is never high without baud_clock.
- With baud_val=0, baud_frac=0, baud_clock may be continuously high. Consumers count cycles; they do not detect edges.
- load together with enable=0: enable wins and the block stays idle.
- reset_n asserted mid-interval: outputs fall to 0 immediately (asynchronously), and any partial stretch is discarded.

## Test plan
- Integer divide: CNT_WIDTH=13, OVERSAMPLE=16, baud_val=3, baud_frac=0 -> baud_clock every 4 clocks; xmit_pulse every 64 clocks, aligned to the 16th tick.
- Half fraction: FRAC_WIDTH=3, baud_val=3, baud_frac=4 -> tick intervals alternate 4,5,4,5; 16 ticks span 72 clocks.
- Minimum fraction: FRAC_WIDTH=3, baud_val=3, baud_frac=1 -> exactly one 5-clock interval per 8 ticks; 8 ticks span 33 clocks.
- Divide-by-one: baud_val=0, baud_frac=0 -> baud_clock constantly 1, xmit_pulse every 16th clock. Then baud_frac=4 -> baud_clock pattern 1,1,0 repeating per accumulator carry.
- Resync and enable: pulse load mid-count with baud_val=9 -> no tick for 9 cycles, tick on the 10th edge, tick_cntr restarted. Drop enable mid-interval -> outputs 0 next cycle; re-raise -> tick on the first enabled edge.
- Async reset: assert reset_n low mid-interval, between clock edges -> baud_clock and xmit_pulse go 0 without a clock edge. After release with enable=1, the cycle-exact sequence of the integer-divide case repeats from tick 1.

Source files
------------

// File: rtl/uart_baud_gen_frac.sv
// Fractional baud-rate tick generator: divides clk by baud_val+1+baud_frac/2^FRAC_WIDTH
// to produce the oversampling baud_clock strobe and the once-per-bit xmit_pulse strobe.
module uart_baud_gen_frac #(
  parameter int unsigned CNT_WIDTH  = 13,
  parameter int unsigned FRAC_WIDTH = 3,
  parameter int unsigned OVERSAMPLE = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  enable,
  input  logic                  load,
  input  logic [CNT_WIDTH-1:0]  baud_val,
  input  logic [FRAC_WIDTH-1:0] baud_frac,
  output logic                  baud_clock,
  output logic                  xmit_pulse
);

  localparam int unsigned         TICK_W    = $clog2(OVERSAMPLE);
  localparam logic [TICK_W-1:0]   TICK_LAST = TICK_W'(OVERSAMPLE - 1);

  logic [CNT_WIDTH-1:0]  cnt, cnt_nxt;
  logic [FRAC_WIDTH-1:0] acc, acc_nxt;
  logic                  stretch, stretch_nxt;
  logic [TICK_W-1:0]     tick_cntr, tick_cntr_nxt;
  logic                  baud_clock_nxt, xmit_pulse_nxt;
  logic [FRAC_WIDTH:0]   acc_sum;

  // Phase accumulator sum; the top bit is the carry that buys one extra hold cycle.
  assign acc_sum = {1'b0, acc} + {1'b0, baud_frac};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt        <= '0;
      acc        <= '0;
      stretch    <= 1'b0;
      tick_cntr  <= '0;
      baud_clock <= 1'b0;
      xmit_pulse <= 1'b0;
    end else begin
      cnt        <= cnt_nxt;
      acc        <= acc_nxt;
      stretch    <= stretch_nxt;
      tick_cntr  <= tick_cntr_nxt;
      baud_clock <= baud_clock_nxt;
      xmit_pulse <= xmit_pulse_nxt;
    end
  end

  // Next state: idle, resync, count down, hold for a carry, or tick and reload.
  always_comb begin
    cnt_nxt        = cnt;
    acc_nxt        = acc;
    stretch_nxt    = stretch;
    tick_cntr_nxt  = tick_cntr;
    baud_clock_nxt = 1'b0;
    xmit_pulse_nxt = 1'b0;

    if (!enable) begin
      cnt_nxt       = '0;
      acc_nxt       = '0;
      stretch_nxt   = 1'b0;
      tick_cntr_nxt = '0;
    end else if (load) begin
      cnt_nxt       = baud_val;
      acc_nxt       = '0;
      stretch_nxt   = 1'b0;
      tick_cntr_nxt = '0;
    end else if (cnt != '0) begin
      cnt_nxt = cnt - CNT_WIDTH'(1);
    end else if (stretch) begin
      stretch_nxt = 1'b0;
    end else begin
      // Divisors are sampled only here, so a change never truncates an interval.
      baud_clock_nxt = 1'b1;
      cnt_nxt        = baud_val;
      acc_nxt        = acc_sum[FRAC_WIDTH-1:0];
      stretch_nxt    = acc_sum[FRAC_WIDTH];
      tick_cntr_nxt  = tick_cntr + TICK_W'(1);
      xmit_pulse_nxt = (tick_cntr == TICK_LAST);
    end
  end

endmodule
